// File: rtl/axil_msi_irq_scheduler_pkg.sv
// Shared types and helpers for the MSI interrupt scheduler.
package msi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int MAX_VEC_W = 5;

  // Source index -> MSI vector. Sources beyond the allocated range share the top vector.
  function automatic logic [MAX_VEC_W-1:0] vec_map(input logic [MAX_VEC_W-1:0] idx,
                                                   input logic [2:0]           width);
    logic [2:0]         w;
    logic [MAX_VEC_W:0] alloc;
    w     = (width > 3'd5) ? 3'd5 : width;
    alloc = (MAX_VEC_W+1)'(1) << w;
    if ({1'b0, idx} < alloc) vec_map = idx;
    else                     vec_map = alloc[MAX_VEC_W-1:0] - 1'b1;
  endfunction

endpackage

// File: rtl/axil_msi_irq_scheduler_if.sv
// MSI request/grant pins between the scheduler and the PCIe core.
interface axil_msi_irq_scheduler_if;
  import msi_sched_pkg::*;

  logic                 msi_enable;
  logic [2:0]           msi_vector_width;
  logic                 intx_msi_request;
  logic                 intx_msi_grant;
  logic [MAX_VEC_W-1:0] msi_vector_num;

  // Scheduler side: issues requests.
  modport master (
    input  msi_enable, msi_vector_width, intx_msi_grant,
    output intx_msi_request, msi_vector_num
  );

  // Core side: grants requests.
  modport slave (
    output msi_enable, msi_vector_width, intx_msi_grant,
    input  intx_msi_request, msi_vector_num
  );
endinterface

// File: rtl/axil_msi_irq_scheduler_arb.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module msi_rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Scan N slots starting from ptr; the first hit wins.
  always_comb begin
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any        = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axil_msi_irq_scheduler.sv
// Shares one MSI request/grant port between NUM_SRC edge-triggered interrupt sources.
module axil_msi_irq_scheduler
  import msi_sched_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic [NUM_SRC-1:0]   irq_mask,
  output logic [NUM_SRC-1:0]   irq_pending,
  output logic [NUM_SRC-1:0]   irq_overflow,
  input  logic [NUM_SRC-1:0]   ovf_clear,
  output logic                 busy,
  axil_msi_irq_scheduler_if.master msi
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [NUM_SRC-1:0]   cur_oh_q, cur_oh_d;
  logic [MAX_VEC_W-1:0] vec_q, vec_d;
  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   ovf_q, ovf_d;

  logic [NUM_SRC-1:0]   evt, elig, gnt_clr, ovf_set;
  logic [NUM_SRC-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 granted;

  // A fresh edge is eligible in its own cycle so the request follows it by one clock.
  assign evt  = irq_src & ~src_q;
  assign elig = (pending_q | evt) & ~irq_mask;

  msi_rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_arb (
    .req     (elig),
    .ptr     (rr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Pending/overflow update; an edge on the granted source in the grant cycle re-arms it quietly.
  always_comb begin
    granted   = (state_q == REQ) && msi.intx_msi_grant;
    gnt_clr   = granted ? cur_oh_q : '0;
    ovf_set   = evt & pending_q & ~gnt_clr;
    pending_d = (pending_q & ~gnt_clr) | evt;
    ovf_d     = (ovf_q & ~ovf_clear) | ovf_set;
  end

  // Request FSM: start from IDLE, hold in REQ until grant, then enforce the idle gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    cur_d    = cur_q;
    cur_oh_d = cur_oh_q;
    vec_d    = vec_q;
    case (state_q)
      IDLE: begin
        if (msi.msi_enable && pick_any) begin
          cur_d    = pick_idx;
          cur_oh_d = pick_oh;
          vec_d    = vec_map(MAX_VEC_W'(pick_idx), msi.msi_vector_width);
          state_d  = REQ;
        end
      end
      REQ: begin
        if (msi.intx_msi_grant) begin
          rr_d = (cur_q == IDX_W'(NUM_SRC-1)) ? '0 : cur_q + 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = 4'(GAP_CYCLES-1);
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops the request and discards all pending work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_q      <= '0;
      cur_q     <= '0;
      cur_oh_q  <= '0;
      vec_q     <= '0;
      src_q     <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      cur_q     <= cur_d;
      cur_oh_q  <= cur_oh_d;
      vec_q     <= vec_d;
      src_q     <= irq_src;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign msi.intx_msi_request = (state_q == REQ);
  assign msi.msi_vector_num   = vec_q;
  assign busy                 = (state_q != IDLE);
  assign irq_pending          = pending_q;
  assign irq_overflow         = ovf_q;

endmodule

// File: tb/tb_axil_msi_irq_scheduler.sv
// Directed checks of the MSI scheduler: latency, round-robin order, vector clamp,
// request hold, overflow, masking and async reset.
module tb_axil_msi_irq_scheduler;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] irq_src, irq_mask, ovf_clear;
  logic [N-1:0] irq_pending, irq_overflow;
  logic         busy;
  int           n_chk, n_fail;

  axil_msi_irq_scheduler_if msi_if();

  axil_msi_irq_scheduler #(.NUM_SRC(N), .GAP_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_src      (irq_src),
    .irq_mask     (irq_mask),
    .irq_pending  (irq_pending),
    .irq_overflow (irq_overflow),
    .ovf_clear    (ovf_clear),
    .busy         (busy),
    .msi          (msi_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq_src = '0; irq_mask = '0; ovf_clear = '0;
    msi_if.intx_msi_grant = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) for a request, check its vector and wait length, then grant it.
  task automatic serve(input string tag, input logic [4:0] exp_vec, input int exp_wait);
    int waited;
    waited = 0;
    while (!msi_if.intx_msi_request && waited < 50) begin
      tick();
      waited++;
    end
    chk({tag, "_req"}, msi_if.intx_msi_request, 1);
    chk({tag, "_vec"}, msi_if.msi_vector_num, exp_vec);
    if (exp_wait >= 0) chk({tag, "_wait"}, waited, exp_wait);
    msi_if.intx_msi_grant = 1'b1;
    tick();
    msi_if.intx_msi_grant = 1'b0;
    chk({tag, "_drop"}, msi_if.intx_msi_request, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    msi_if.msi_enable = 1'b1;
    msi_if.msi_vector_width = 3'd3;
    msi_if.intx_msi_grant = 1'b0;
    rst_n = 1'b0;
    irq_src = '0; irq_mask = '0; ovf_clear = '0;
    tick();
    chk("rst_req",  msi_if.intx_msi_request, 0);
    chk("rst_vec",  msi_if.msi_vector_num, 0);
    chk("rst_pend", irq_pending, 0);
    chk("rst_ovf",  irq_overflow, 0);
    chk("rst_busy", busy, 0);

    // 1: single source, latency, grant after 4 cycles, 2-cycle gap
    do_reset();
    irq_src[3] = 1'b1;
    chk("t1_pre", msi_if.intx_msi_request, 0);
    tick();
    irq_src[3] = 1'b0;
    chk("t1_req", msi_if.intx_msi_request, 1);
    chk("t1_vec", msi_if.msi_vector_num, 3);
    chk("t1_pend", irq_pending, 8'h08);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_hold", msi_if.intx_msi_request, 1);
    end
    msi_if.intx_msi_grant = 1'b1;
    tick();
    msi_if.intx_msi_grant = 1'b0;
    chk("t1_drop", msi_if.intx_msi_request, 0);
    chk("t1_clr", irq_pending, 0);
    chk("t1_gap1", busy, 1);
    tick();
    chk("t1_gap2", busy, 1);
    tick();
    chk("t1_idle", busy, 0);

    // 2: simultaneous 1,5,6 from rr=0; then rr at 7 picks 7 before 0
    do_reset();
    irq_src = 8'b0110_0010;
    tick();
    irq_src = '0;
    serve("t2a", 5'd1, 0);
    serve("t2b", 5'd5, 3);
    serve("t2c", 5'd6, 3);
    irq_src = 8'h81;
    tick();
    irq_src = '0;
    serve("t2d", 5'd7, -1);
    serve("t2e", 5'd0, 3);

    // 3: two vectors, source 6 clamps to vector 1
    do_reset();
    msi_if.msi_vector_width = 3'd1;
    irq_src = 8'h41;
    tick();
    irq_src = '0;
    serve("t3a", 5'd0, 0);
    serve("t3b", 5'd1, 3);
    msi_if.msi_vector_width = 3'd3;

    // 4: long grant delay with enable dropped mid-request
    do_reset();
    irq_src[5] = 1'b1;
    tick();
    irq_src = '0;
    chk("t4_req", msi_if.intx_msi_request, 1);
    msi_if.msi_enable = 1'b0;
    irq_src[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      irq_src = '0;
      chk("t4_hold_req", msi_if.intx_msi_request, 1);
      chk("t4_hold_vec", msi_if.msi_vector_num, 5);
    end
    msi_if.intx_msi_grant = 1'b1;
    tick();
    msi_if.intx_msi_grant = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t4_noreq", msi_if.intx_msi_request, 0);
      tick();
    end
    chk("t4_pend", irq_pending, 8'h04);
    msi_if.msi_enable = 1'b1;
    tick();
    chk("t4_req2", msi_if.intx_msi_request, 1);
    chk("t4_vec2", msi_if.msi_vector_num, 2);

    // 5: overflow on repeat edge, re-arm in grant cycle, write-1-to-clear
    do_reset();
    irq_src[4] = 1'b1;
    tick();
    chk("t5_req", msi_if.intx_msi_request, 1);
    chk("t5_ovf0", irq_overflow, 0);
    irq_src[4] = 1'b0;
    tick();
    irq_src[4] = 1'b1;
    tick();
    chk("t5_ovf1", irq_overflow, 8'h10);
    irq_src[4] = 1'b0;
    tick();
    irq_src[4] = 1'b1;
    msi_if.intx_msi_grant = 1'b1;
    tick();
    irq_src[4] = 1'b0;
    msi_if.intx_msi_grant = 1'b0;
    chk("t5_pend", irq_pending, 8'h10);
    chk("t5_ovf2", irq_overflow, 8'h10);
    ovf_clear[4] = 1'b1;
    tick();
    ovf_clear = '0;
    chk("t5_ovfclr", irq_overflow, 0);

    // 6: masked source waits, unmask starts it; async reset mid-request
    do_reset();
    irq_mask[2] = 1'b1;
    irq_src[2] = 1'b1;
    tick();
    irq_src = '0;
    tick(); tick();
    chk("t6_noreq", msi_if.intx_msi_request, 0);
    chk("t6_pend", irq_pending, 8'h04);
    irq_mask = '0;
    tick();
    chk("t6_req", msi_if.intx_msi_request, 1);
    chk("t6_vec", msi_if.msi_vector_num, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", msi_if.intx_msi_request, 0);
    chk("t6_rst_pend", irq_pending, 0);
    chk("t6_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
